decode_stage: RTL and testbench

Decode stage of the single-issue MIPS pipeline, directly downstream of the fetch unit. Captures each fetched instruction in an IF/ID register, decodes LW, SW, J, JR, BNE, XORI, ADD, SUB and SLT into control and field outputs, and registers them into an ID/EX register for execute. Detects load-use hazards, raising Stall to freeze fetch while inserting a bubble. Honours a Flush from execute on taken BNE/J/JR.

---
 rtl/decode_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: IF/ID capture, MIPS-subset decode (LW SW J JR BNE XORI ADD SUB SLT),
// load-use hazard detection and ID/EX register feeding execute.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN enables the sticky Illegal flag.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Flush,
  input  logic        ExMemRead,
  input  logic [4:0]  ExRt,
  output logic        Stall,
  output logic        Valid,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        ZeroExt,
  output logic        Branch,
  output logic        Jump,
  output logic        JR,
  output logic [2:0]  ALUCtrl,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [15:0] Imm16,
  output logic [25:0] TargetInstr,
  output logic        Illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        alu_src;
    logic        zero_ext;
    logic        branch;
    logic        jump;
    logic        jr;
    logic [2:0]  alu_ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [25:0] target;
  } idex_t;

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  idex_t       idex_q, idex_d;
  idex_t       dec;
  logic        rs_used, rt_used;
  logic        issue;

  logic [5:0] opcode, funct;
  assign opcode = ifid_instr_q[31:26];
  assign funct  = ifid_instr_q[5:0];

  // Decode the IF/ID instruction; unknown encodings (and 32'h0) fall through as a NOP.
  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.rs     = ifid_instr_q[25:21];
    dec.rt     = ifid_instr_q[20:16];
    dec.rd     = ifid_instr_q[15:11];
    dec.imm16  = ifid_instr_q[15:0];
    dec.target = ifid_instr_q[25:0];
    rs_used    = 1'b0;
    rt_used    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_ctrl = ALU_ADD;
            rs_used = 1'b1; rt_used = 1'b1;
          end
          FN_SUB: begin
            dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_ctrl = ALU_SUB;
            rs_used = 1'b1; rt_used = 1'b1;
          end
          FN_SLT: begin
            dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_ctrl = ALU_SLT;
            rs_used = 1'b1; rt_used = 1'b1;
          end
          FN_JR: begin
            dec.jr = 1'b1; dec.jump = 1'b1;
            rs_used = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
        dec.alu_src = 1'b1; dec.alu_ctrl = ALU_ADD;
        rs_used = 1'b1;
      end
      OP_SW: begin
        dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.alu_ctrl = ALU_ADD;
        rs_used = 1'b1; rt_used = 1'b1;
      end
      OP_J: begin
        dec.jump = 1'b1;
      end
      OP_BNE: begin
        dec.branch = 1'b1; dec.alu_ctrl = ALU_SUB;
        rs_used = 1'b1; rt_used = 1'b1;
      end
      OP_XORI: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.zero_ext = 1'b1;
        dec.alu_ctrl = ALU_XOR;
        rs_used = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use hazard: the LW in execute writes a register the IF/ID instruction reads.
  always_comb begin
    Stall = ifid_valid_q & ExMemRead & (ExRt != 5'd0) & ~Flush &
            ((rs_used & (ExRt == dec.rs)) | (rt_used & (ExRt == dec.rt)));
  end

  assign issue = ifid_valid_q & ~Flush & ~Stall;

  // Next-state for IF/ID and ID/EX: Flush clears both, Stall holds IF/ID and bubbles ID/EX.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    idex_d       = '0;
    if (Flush) begin
      ifid_valid_d = 1'b0;
    end else if (!Stall) begin
      ifid_instr_d = Instr;
      ifid_valid_d = 1'b1;
      if (ifid_valid_q) idex_d = dec;
    end
  end

  // Pipeline registers; reset empties both stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      idex_q       <= '0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic dec_illegal;
  logic illegal_q, illegal_d;

  // Flag any encoding outside the supported set, except the all-zero NOP.
  always_comb begin
    dec_illegal = 1'b1;
    if (ifid_instr_q == 32'h0) begin
      dec_illegal = 1'b0;
    end else begin
      case (opcode)
        OP_RTYPE: dec_illegal = !(funct inside {FN_ADD, FN_SUB, FN_SLT, FN_JR});
        OP_J, OP_BNE, OP_XORI, OP_LW, OP_SW: dec_illegal = 1'b0;
        default: dec_illegal = 1'b1;
      endcase
    end
    illegal_d = illegal_q | (issue & dec_illegal);
  end

  // Sticky illegal flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

  assign Valid       = idex_q.valid;
  assign RegWrite    = idex_q.reg_write;
  assign MemRead     = idex_q.mem_read;
  assign MemWrite    = idex_q.mem_write;
  assign MemToReg    = idex_q.mem_to_reg;
  assign RegDst      = idex_q.reg_dst;
  assign ALUSrc      = idex_q.alu_src;
  assign ZeroExt     = idex_q.zero_ext;
  assign Branch      = idex_q.branch;
  assign Jump        = idex_q.jump;
  assign JR          = idex_q.jr;
  assign ALUCtrl     = idex_q.alu_ctrl;
  assign Rs          = idex_q.rs;
  assign Rt          = idex_q.rt;
  assign Rd          = idex_q.rd;
  assign Imm16       = idex_q.imm16;
  assign TargetInstr = idex_q.target;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic for decode_stage,
// checked against an instruction-level reference model of the decode stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, Flush, ExMemRead;
  logic [31:0] Instr;
  logic [4:0]  ExRt;
  logic        Stall, Valid, RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc, ZeroExt;
  logic        Branch, Jump, JR, Illegal;
  logic [2:0]  ALUCtrl;
  logic [4:0]  Rs, Rt, Rd;
  logic [15:0] Imm16;
  logic [25:0] TargetInstr;

  int checks = 0;
  int errors = 0;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int K_NOP = 0, K_ADD = 1, K_SUB = 2, K_SLT = 3, K_JR = 4, K_LW = 5;
  localparam int K_SW = 6, K_J = 7, K_BNE = 8, K_XORI = 9, K_ILL = 10;

  localparam logic [31:0] ADD_3_1_2 = 32'h00221820;
  localparam logic [31:0] LW_5_4_1  = {6'h23, 5'd1, 5'd5, 16'd4};
  localparam logic [31:0] SUB_6_5_2 = {6'h00, 5'd5, 5'd2, 5'd6, 5'd0, 6'h22};
  localparam logic [31:0] SUB_6_0_2 = {6'h00, 5'd0, 5'd2, 5'd6, 5'd0, 6'h22};

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Flush(Flush), .ExMemRead(ExMemRead), .ExRt(ExRt),
    .Stall(Stall), .Valid(Valid), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .ALUSrc(ALUSrc), .ZeroExt(ZeroExt), .Branch(Branch),
    .Jump(Jump), .JR(JR), .ALUCtrl(ALUCtrl), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm16(Imm16),
    .TargetInstr(TargetInstr), .Illegal(Illegal)
  );

  logic [70:0] dut_vec;
  assign dut_vec = {Valid, RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc, ZeroExt,
                    Branch, Jump, JR, ALUCtrl, Rs, Rt, Rd, Imm16, TargetInstr};

  // Reference model state: what sits in IF/ID, what ID/EX should show, the sticky flag.
  logic        m_ifv = 1'b0;
  logic [31:0] m_ifi = '0;
  logic [70:0] m_out = '0;
  logic        m_ill = 1'b0;

  function automatic int classify(input logic [31:0] i);
    if (i == 32'h0) return K_NOP;
    case (i[31:26])
      6'h00: case (i[5:0])
               6'h20: return K_ADD;
               6'h22: return K_SUB;
               6'h2A: return K_SLT;
               6'h08: return K_JR;
               default: return K_ILL;
             endcase
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h02: return K_J;
      6'h05: return K_BNE;
      6'h0E: return K_XORI;
      default: return K_ILL;
    endcase
  endfunction

  // Expected ID/EX contents for a valid instruction.
  function automatic logic [70:0] model_decode(input logic [31:0] i);
    logic rw, mr, mw, m2r, rdst, asrc, ze, br, j, jr;
    logic [2:0] alu;
    {rw, mr, mw, m2r, rdst, asrc, ze, br, j, jr} = '0;
    alu = 3'd0;
    case (classify(i))
      K_ADD:  begin rw = 1; rdst = 1; alu = 3'd0; end
      K_SUB:  begin rw = 1; rdst = 1; alu = 3'd1; end
      K_SLT:  begin rw = 1; rdst = 1; alu = 3'd2; end
      K_JR:   begin jr = 1; j = 1; end
      K_LW:   begin rw = 1; mr = 1; m2r = 1; asrc = 1; end
      K_SW:   begin mw = 1; asrc = 1; end
      K_J:    j = 1;
      K_BNE:  begin br = 1; alu = 3'd1; end
      K_XORI: begin rw = 1; asrc = 1; ze = 1; alu = 3'd3; end
      default: ;
    endcase
    return {1'b1, rw, mr, mw, m2r, rdst, asrc, ze, br, j, jr, alu,
            i[25:21], i[20:16], i[15:11], i[15:0], i[25:0]};
  endfunction

  function automatic logic exp_stall();
    int k;
    logic rsu, rtu;
    k = classify(m_ifi);
    rsu = k inside {K_ADD, K_SUB, K_SLT, K_JR, K_LW, K_SW, K_BNE, K_XORI};
    rtu = k inside {K_ADD, K_SUB, K_SLT, K_SW, K_BNE};
    return m_ifv && ExMemRead && (ExRt != 5'd0) && !Flush &&
           ((rsu && ExRt == m_ifi[25:21]) || (rtu && ExRt == m_ifi[20:16]));
  endfunction

  function automatic logic [31:0] mk(input int k);
    logic [4:0] a, b, c;
    logic [15:0] im;
    logic [25:0] t;
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
    im = 16'($urandom); t = 26'($urandom);
    case (k)
      K_ADD:  return {6'h00, a, b, c, 5'd0, 6'h20};
      K_SUB:  return {6'h00, a, b, c, 5'd0, 6'h22};
      K_SLT:  return {6'h00, a, b, c, 5'd0, 6'h2A};
      K_JR:   return {6'h00, a, 15'd0, 6'h08};
      K_LW:   return {6'h23, a, b, im};
      K_SW:   return {6'h2B, a, b, im};
      K_J:    return {6'h02, t};
      K_BNE:  return {6'h05, a, b, im};
      K_XORI: return {6'h0E, a, b, im};
      K_ILL:  return ($urandom_range(0, 1) == 0) ? {6'h3F, t} : {6'h00, a, b, c, 5'd0, 6'h01};
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven, then step the DUT.
  task automatic tick();
    logic st;
    st = exp_stall();
    if (reset) begin
      m_ifv = 1'b0; m_out = '0; m_ill = 1'b0;
    end else if (Flush) begin
      m_ifv = 1'b0; m_out = '0;
    end else if (st) begin
      m_out = '0;
    end else begin
      m_out = m_ifv ? model_decode(m_ifi) : '0;
      if (TRAP && m_ifv && classify(m_ifi) == K_ILL) m_ill = 1'b1;
      m_ifi = Instr;
      m_ifv = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic f, input logic emr, input logic [4:0] ert);
    Instr = i; Flush = f; ExMemRead = emr; ExRt = ert;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 5'd0);
    tick(); tick();
    #4;
    checks++; if (dut_vec !== 71'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", dut_vec); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
    checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", Illegal); end
  endtask

  task automatic test_add();
    reset = 1'b0;
    drive(ADD_3_1_2, 1'b0, 1'b0, 5'd0); tick();
    drive(32'h0, 1'b0, 1'b0, 5'd0); tick();
    #4;
    checks++;
    if ({Valid, RegWrite, RegDst, ALUCtrl, Rs, Rt, Rd} !== {1'b1, 1'b1, 1'b1, 3'b000, 5'd1, 5'd2, 5'd3}) begin
      errors++;
      $display("FAIL add_fields: got V%b RW%b RD%b alu%b rs%0d rt%0d rd%0d want V1 RW1 RD1 alu000 rs1 rt2 rd3",
               Valid, RegWrite, RegDst, ALUCtrl, Rs, Rt, Rd);
    end
    checks++; if (dut_vec !== m_out) begin errors++; $display("FAIL add_vec: got %h want %h", dut_vec, m_out); end
  endtask

  task automatic test_load_use();
    drive(LW_5_4_1, 1'b0, 1'b0, 5'd0); tick();
    drive(SUB_6_5_2, 1'b0, 1'b0, 5'd0); tick();
    drive(ADD_3_1_2, 1'b0, 1'b1, 5'd5);
    #4;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", Stall); end
    checks++; if ({Valid, MemRead} !== 2'b11) begin errors++; $display("FAIL lu_lw_issued: got %b want 11", {Valid, MemRead}); end
    tick();
    drive(ADD_3_1_2, 1'b0, 1'b0, 5'd0);
    #4;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL lu_stall_one_cycle: got %b want 0", Stall); end
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b want 0", Valid); end
    tick();
    #4;
    checks++;
    if ({Valid, ALUCtrl, Rd} !== {1'b1, 3'b001, 5'd6}) begin
      errors++; $display("FAIL lu_sub_issue: got V%b alu%b rd%0d want V1 alu001 rd6", Valid, ALUCtrl, Rd);
    end
    checks++; if (dut_vec !== m_out) begin errors++; $display("FAIL lu_vec: got %h want %h", dut_vec, m_out); end
  endtask

  task automatic test_zero_rt();
    drive(SUB_6_0_2, 1'b0, 1'b0, 5'd0); tick();
    drive(ADD_3_1_2, 1'b0, 1'b1, 5'd0);
    #4;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL zero_rt_stall: got %b want 0", Stall); end
    tick();
    drive(ADD_3_1_2, 1'b0, 1'b0, 5'd0);
    #4;
    checks++; if (dut_vec !== m_out) begin errors++; $display("FAIL zero_rt_vec: got %h want %h", dut_vec, m_out); end
  endtask

  task automatic test_bne_flush();
    drive(32'h1422FFFE, 1'b0, 1'b0, 5'd0); tick();
    drive(ADD_3_1_2, 1'b0, 1'b0, 5'd0); tick();
    #4;
    checks++;
    if ({Valid, Branch, ALUCtrl, Imm16} !== {1'b1, 1'b1, 3'b001, 16'hFFFE}) begin
      errors++; $display("FAIL bne_issue: got V%b B%b alu%b imm%h want V1 B1 alu001 immfffe", Valid, Branch, ALUCtrl, Imm16);
    end
    drive(ADD_3_1_2, 1'b1, 1'b0, 5'd0); tick();
    drive(ADD_3_1_2, 1'b0, 1'b0, 5'd0);
    #4;
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL bne_bubble1: got %b want 0", Valid); end
    tick();
    #4;
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL bne_bubble2: got %b want 0", Valid); end
    tick();
    #4;
    checks++; if (dut_vec !== m_out) begin errors++; $display("FAIL bne_resume: got %h want %h", dut_vec, m_out); end
  endtask

  task automatic test_flush_stall();
    drive(LW_5_4_1, 1'b0, 1'b0, 5'd0); tick();
    drive(SUB_6_5_2, 1'b0, 1'b0, 5'd0); tick();
    drive(ADD_3_1_2, 1'b1, 1'b1, 5'd5);
    #4;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL fs_stall: got %b want 0", Stall); end
    tick();
    drive(ADD_3_1_2, 1'b0, 1'b0, 5'd0);
    #4;
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL fs_idex_clear: got %b want 0", Valid); end
    tick();
    #4;
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL fs_ifid_clear: got %b want 0", Valid); end
  endtask

  task automatic test_illegal();
    drive(32'hFC000000, 1'b0, 1'b0, 5'd0); tick();
    drive(ADD_3_1_2, 1'b0, 1'b0, 5'd0); tick();
    #4;
    checks++;
    if ({Valid, RegWrite, MemRead, MemWrite, Branch, Jump, JR} !== 7'b1000000) begin
      errors++; $display("FAIL ill_nop: got %b want 1000000", {Valid, RegWrite, MemRead, MemWrite, Branch, Jump, JR});
    end
    checks++; if (Illegal !== TRAP) begin errors++; $display("FAIL ill_flag: got %b want %b", Illegal, TRAP); end
    for (int n = 0; n < 3; n++) tick();
    #4;
    checks++; if (Illegal !== TRAP) begin errors++; $display("FAIL ill_sticky: got %b want %b", Illegal, TRAP); end
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL ill_later_add: got %b want 1", RegWrite); end
  endtask

  task automatic test_reset_mid();
    drive(LW_5_4_1, 1'b0, 1'b0, 5'd0); tick();
    drive(SUB_6_5_2, 1'b0, 1'b0, 5'd0); tick();
    drive(ADD_3_1_2, 1'b0, 1'b1, 5'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #4;
    checks++; if (dut_vec !== 71'd0) begin errors++; $display("FAIL rmid_outputs: got %h want 0", dut_vec); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b want 0", Stall); end
    checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL rmid_illegal: got %b want 0", Illegal); end
    drive(ADD_3_1_2, 1'b0, 1'b0, 5'd0);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive(mk($urandom_range(0, 10)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
      #4;
      checks++; if (Stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, Stall, exp_stall()); end
      checks++; if (dut_vec !== m_out) begin errors++; $display("FAIL rnd_vec[%0d]: got %h want %h", n, dut_vec, m_out); end
      checks++; if (Illegal !== m_ill) begin errors++; $display("FAIL rnd_illegal[%0d]: got %b want %b", n, Illegal, m_ill); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 5'd0);
    test_reset();
    test_add();
    test_load_use();
    test_zero_rt();
    test_bne_flush();
    test_flush_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
